// File: rtl/bsg_downstream_in.sv
// bsg_downstream_in
//   Receive side of the two-channel byte-serial link. Four beats of two bytes
//   each are reassembled into a 64-bit packet, which is queued in a circular
//   FIFO toward the core. One credit token is returned per packet the core
//   consumes.
//
// Optional feature macro: BSG_DOWNSTREAM_IN_OVERFLOW_CHECK_EN
//   Defined   : err_overflow_out latches on any packet dropped because the
//               FIFO was full, and is cleared only by rst.
//   Undefined : err_overflow_out is tied to 0. Drops happen either way.
//
// Parameters
//   ELS    FIFO depth in packets (power of two, 2..64)
//   PTR_W  pointer width, derived from ELS
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   io_valid_in       link beat valid
//   io_data_in_ch0/1  link bytes for channel 0 / channel 1
//   io_token_out      one-cycle credit pulse per consumed packet
//   core_valid_out    FIFO head valid
//   core_data_out     FIFO head packet
//   core_yumi_in      core consumes the head this cycle
//   count_out         packets currently buffered (0..ELS)
//   err_overflow_out  sticky overflow flag
module bsg_downstream_in #(
  parameter int ELS   = 64,
  parameter int PTR_W = $clog2(ELS)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        io_valid_in,
  input  logic [7:0]  io_data_in_ch0,
  input  logic [7:0]  io_data_in_ch1,
  output logic        io_token_out,
  output logic        core_valid_out,
  output logic [63:0] core_data_out,
  input  logic        core_yumi_in,
  output logic [6:0]  count_out,
  output logic        err_overflow_out
);

  localparam logic [6:0] ELS_C = 7'(ELS);

  logic [1:0]       step_q, step_d;
  logic [47:0]      asm_q, asm_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [6:0]       count_q, count_d;
  logic             token_q;

  logic [63:0] mem [ELS];

  logic        last_beat;
  logic        full;
  logic        empty;
  logic        enq;
  logic        deq;
  logic [63:0] pkt;

  assign last_beat = io_valid_in && (step_q == 2'd3);
  assign full      = (count_q == ELS_C);
  assign empty     = (count_q == 7'd0);
  // Drop decision uses the registered count: a same-cycle dequeue does not
  // open a slot for the arriving packet.
  assign enq       = last_beat && !full;
  assign deq       = core_yumi_in && !empty;

  // Assembly register layout: [39:0] holds packet bits [39:0], [47:40] holds
  // packet bits [55:48]. The final beat supplies bits [47:40] and [63:56].
  assign pkt = {io_data_in_ch1, asm_q[47:40], io_data_in_ch0, asm_q[39:0]};

  always_comb begin
    asm_d  = asm_q;
    step_d = step_q;
    if (io_valid_in) begin
      step_d = step_q + 2'd1;
      case (step_q)
        2'd0: begin
          asm_d[7:0]   = io_data_in_ch0;
          asm_d[23:16] = io_data_in_ch1;
        end
        2'd1: begin
          asm_d[15:8]  = io_data_in_ch0;
          asm_d[31:24] = io_data_in_ch1;
        end
        2'd2: begin
          asm_d[39:32] = io_data_in_ch0;
          asm_d[47:40] = io_data_in_ch1;
        end
        default: ; // final beat goes straight into the FIFO
      endcase
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({enq, deq})
      2'b10:   count_d = count_q + 7'd1;
      2'b01:   count_d = count_q - 7'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      step_q   <= 2'd0;
      asm_q    <= 48'd0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= 7'd0;
      token_q  <= 1'b0;
    end else begin
      step_q   <= step_d;
      asm_q    <= asm_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      token_q  <= deq;
    end
  end

  // Storage is not reset; the count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr_q] <= pkt;
  end

  assign core_data_out  = mem[rd_ptr_q];
  assign core_valid_out = !empty;
  assign count_out      = count_q;
  assign io_token_out   = token_q;

`ifdef BSG_DOWNSTREAM_IN_OVERFLOW_CHECK_EN
  logic ovf_q;
  always_ff @(posedge clk) begin
    if (rst)                    ovf_q <= 1'b0;
    else if (last_beat && full) ovf_q <= 1'b1;
  end
  assign err_overflow_out = ovf_q;
`else
  assign err_overflow_out = 1'b0;
`endif

endmodule
